// File: rtl/run_pattern_tx_if.sv
// Descriptor request channel for run_pattern_tx.
// A descriptor (run length of 1s, gap length of 0s, repeat count) is transferred on a
// clock edge where req_valid && req_ready.
//   req_valid    master -> slave  descriptor valid
//   req_ready    slave  -> master transmitter idle, can accept
//   req_run_len  master -> slave  1 bits per burst
//   req_gap_len  master -> slave  0 bits per burst, following the run
//   req_repeat   master -> slave  bursts to send (0 treated as 1)
interface run_pattern_tx_if #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned REP_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [LEN_W-1:0] req_run_len;
  logic [LEN_W-1:0] req_gap_len;
  logic [REP_W-1:0] req_repeat;

  modport master (
    output req_valid,
    output req_run_len,
    output req_gap_len,
    output req_repeat,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_run_len,
    input  req_gap_len,
    input  req_repeat,
    output req_ready
  );
endinterface

// File: rtl/run_pattern_tx.sv
// Serial run-pattern transmitter.
// Accepts a burst descriptor over the req interface and drives rep x (run 1s, gap 0s)
// onto tx_bit, one bit consumed per tx_en edge. exp_out predicts the consecutive-ones
// detector output (1 iff the last two consumed bits were both 1).
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   req        descriptor channel (slave side)
//   tx_en      bit strobe; current bit consumed on an edge with tx_en=1
//   tx_bit     serial data (1 in RUN)
//   tx_active  a pattern bit is being presented
//   exp_out    predicted detector output
//   done       one-cycle pulse after the last bit of a descriptor is consumed
module run_pattern_tx #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned REP_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  run_pattern_tx_if.slave     req,
  input  logic                tx_en,
  output logic                tx_bit,
  output logic                tx_active,
  output logic                exp_out,
  output logic                done
);

  typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] run_q, run_d;
  logic [LEN_W-1:0] gap_q, gap_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  // Saturating count of consecutive consumed 1s (0, 1, 2).
  logic [1:0]       ones_q, ones_d;
  logic             done_q, done_d;
  logic             consume;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      run_q   <= '0;
      gap_q   <= '0;
      rep_q   <= '0;
      cnt_q   <= '0;
      ones_q  <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      gap_q   <= gap_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    gap_d   = gap_q;
    rep_d   = rep_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    done_d  = 1'b0;
    consume = tx_en && (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (req.req_valid) begin
          run_d = req.req_run_len;
          gap_d = req.req_gap_len;
          rep_d = (req.req_repeat == '0) ? REP_W'(1) : req.req_repeat;
          if (req.req_run_len != '0) begin
            state_d = StRun;
            cnt_d   = req.req_run_len;
          end else if (req.req_gap_len != '0) begin
            state_d = StGap;
            cnt_d   = req.req_gap_len;
          end else begin
            // Empty descriptor: nothing to send, complete immediately.
            done_d = 1'b1;
          end
        end
      end
      StRun, StGap: begin
        if (tx_en) begin
          if (cnt_q == LEN_W'(1)) begin
            if ((state_q == StRun) && (gap_q != '0)) begin
              state_d = StGap;
              cnt_d   = gap_q;
            end else begin
              // Burst boundary.
              rep_d = rep_q - REP_W'(1);
              if (rep_q > REP_W'(1)) begin
                if (run_q != '0) begin
                  state_d = StRun;
                  cnt_d   = run_q;
                end else begin
                  state_d = StGap;
                  cnt_d   = gap_q;
                end
              end else begin
                state_d = StIdle;
                cnt_d   = '0;
                done_d  = 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Ones history follows consumed bits only; holds in IDLE and across bursts.
    if (consume) begin
      if (state_q == StRun) begin
        ones_d = (ones_q == 2'd2) ? 2'd2 : ones_q + 2'd1;
      end else begin
        ones_d = 2'd0;
      end
    end
  end

  // Outputs, decoded from registered state only
  always_comb begin
    tx_bit        = (state_q == StRun);
    tx_active     = (state_q != StIdle);
    req.req_ready = (state_q == StIdle);
    exp_out       = ones_q[1];
    done          = done_q;
  end

endmodule

// File: tb/tb_run_pattern_tx.sv
module tb_run_pattern_tx;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned REP_W = 4;

  logic clk;
  logic reset_n;
  logic tx_en;
  logic tx_bit;
  logic tx_active;
  logic exp_out;
  logic done;

  int n_assert = 0;
  int n_fail   = 0;

  run_pattern_tx_if #(.LEN_W(LEN_W), .REP_W(REP_W)) req_if ();

  run_pattern_tx #(.LEN_W(LEN_W), .REP_W(REP_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req_if.slave),
    .tx_en     (tx_en),
    .tx_bit    (tx_bit),
    .tx_active (tx_active),
    .exp_out   (exp_out),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Present a descriptor; the next step() is the accept edge.
  task automatic send(input int run, input int gap, input int rep, input logic en);
    req_if.req_valid   = 1'b1;
    req_if.req_run_len = LEN_W'(run);
    req_if.req_gap_len = LEN_W'(gap);
    req_if.req_repeat  = REP_W'(rep);
    tx_en              = en;
  endtask

  function automatic logic ch(input string s, input int i);
    return (s[i] == "1");
  endfunction

  // Checks cycles 1..n after an accept (caller is already in cycle 1). Character i of
  // each string is the value in cycle i+1; en[i] drives tx_en for the edge ending it.
  // Returns in cycle n without stepping past it.
  task automatic run_check(input string tag, input int n, input string en, input string txs,
                           input string exps, input string dns, input string acts);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s c%0d tx_bit", tag, i + 1), 32'(tx_bit), 32'(ch(txs, i)));
      check($sformatf("%s c%0d exp_out", tag, i + 1), 32'(exp_out), 32'(ch(exps, i)));
      check($sformatf("%s c%0d done", tag, i + 1), 32'(done), 32'(ch(dns, i)));
      check($sformatf("%s c%0d tx_active", tag, i + 1), 32'(tx_active), 32'(ch(acts, i)));
      check($sformatf("%s c%0d req_ready", tag, i + 1), 32'(req_if.req_ready),
            32'(!ch(acts, i)));
      if (i < n - 1) begin
        tx_en = ch(en, i);
        step();
      end
    end
  endtask

  initial begin
    reset_n            = 1'b0;
    tx_en              = 1'b0;
    req_if.req_valid   = 1'b0;
    req_if.req_run_len = '0;
    req_if.req_gap_len = '0;
    req_if.req_repeat  = '0;
    step();
    step();
    check("reset req_ready", 32'(req_if.req_ready), 32'd1);
    check("reset tx_active", 32'(tx_active), 32'd0);
    check("reset tx_bit", 32'(tx_bit), 32'd0);
    check("reset exp_out", 32'(exp_out), 32'd0);
    check("reset done", 32'(done), 32'd0);
    reset_n = 1'b1;
    step();

    // Basic burst: 3 ones, 2 zeros.
    send(3, 2, 1, 1'b1);
    step();
    req_if.req_valid = 1'b0;
    run_check("basic", 6, "111111", "111000", "001100", "000001", "111110");
    step();

    // Alternating 1010 x4: exp_out never rises.
    send(1, 1, 4, 1'b1);
    step();
    req_if.req_valid = 1'b0;
    run_check("alt", 9, "111111111", "101010100", "000000000", "000000001", "111111110");
    step();

    // Strobe every other edge, contiguous runs (gap 0, rep 2).
    send(2, 0, 2, 1'b0);
    step();
    req_if.req_valid = 1'b0;
    run_check("stretch", 9, "010101011", "111111110", "000011111", "000000001",
              "111111110");
    step();

    // Empty descriptor with rep 3: done at once, exp_out keeps its 1.
    send(0, 0, 3, 1'b1);
    step();
    req_if.req_valid = 1'b0;
    run_check("empty", 2, "11", "00", "11", "10", "00");

    // Reset mid-RUN of a 5-bit run.
    send(5, 0, 1, 1'b1);
    step();
    req_if.req_valid = 1'b0;
    check("mid c1 tx_bit", 32'(tx_bit), 32'd1);
    step();
    step();
    check("mid c3 exp_out", 32'(exp_out), 32'd1);
    check("mid c3 tx_active", 32'(tx_active), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst tx_bit", 32'(tx_bit), 32'd0);
    check("async rst tx_active", 32'(tx_active), 32'd0);
    check("async rst exp_out", 32'(exp_out), 32'd0);
    check("async rst req_ready", 32'(req_if.req_ready), 32'd1);
    check("async rst done", 32'(done), 32'd0);
    step();
    check("in rst done", 32'(done), 32'd0);
    reset_n = 1'b1;
    step();
    check("post rst done", 32'(done), 32'd0);
    check("post rst req_ready", 32'(req_if.req_ready), 32'd1);
    send(2, 1, 1, 1'b1);
    step();
    req_if.req_valid = 1'b0;
    run_check("postrst", 4, "1111", "1100", "0010", "0001", "1110");
    step();

    // Busy: run=7 held valid during a burst is ignored; a new descriptor is taken in
    // the done cycle and its first bit appears in the next cycle.
    send(3, 1, 1, 1'b1);
    step();
    req_if.req_run_len = LEN_W'(7);
    req_if.req_gap_len = LEN_W'(0);
    req_if.req_repeat  = REP_W'(1);
    run_check("busy", 5, "11111", "11100", "00110", "00001", "11110");
    req_if.req_run_len = LEN_W'(1);
    req_if.req_gap_len = LEN_W'(2);
    step();
    req_if.req_valid = 1'b0;
    run_check("b2b", 4, "1111", "1000", "0000", "0001", "1110");
    step();
    check("final req_ready", 32'(req_if.req_ready), 32'd1);
    check("final done", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
